tmds_encoder: RTL and testbench
===============================

Name: tmds_encoder

Overview:
- DVI/HDMI TMDS 8b/10b encoder for one colour channel, placed directly upstream of the 10:1 serializer in the hdmi_colorbar path.
- Instantiated three times, one per B/G/R channel, all in the pixel clock domain.
- Converts 8-bit pixel data plus DE, C0 and C1 into DC-balanced 10-bit TMDS characters, using running-disparity tracking.
- The serializer transmits data_out[0] first.

Parameters:
- none

Ports:
- sys_clk  input  1  pixel clock; all logic is on the rising edge
- sys_rst_n  input  1  synchronous reset, active-low
- data_in  input  8  pixel component, sampled every cycle
- c0  input  1  control bit 0 (HSYNC on the blue channel, else 0)
- c1  input  1  control bit 1 (VSYNC on the blue channel, else 0)
- de  input  1  data enable; 1 = active video, 0 = blanking/control
- data_out  output  10  registered TMDS character

Behaviour:
Reset and clocking:
- One clock domain, sys_clk. Reset is synchronous and active-low, sampled on the sys_clk rising edge.
- During reset, data_out = 10'h000, disparity cnt = 0, and all pipeline registers (data, de, c0, c1, q_m, counts) = 0.
- Reset asserted mid-stream clears everything on the next edge. Outputs return to normal after the third valid edge once reset is released.

Pipeline (fixed latency 3 cycles, no stalls, no handshake):
- S1: register data_in, de, c0, c1. Compute n1d = popcount(data_in), 4 bits.
- S2: build 9-bit q_m, register it with de/c0/c1. Register n1q and n0q = popcount of q_m[7:0] and its complement, 4 bits each.
- S3: register data_out and update cnt.
- Result: inputs present at edge N appear on data_out after edge N+3.

Building q_m (S2):
- XNOR mode when n1d>4, or when n1d==4 and d[0]==0. Otherwise XOR mode.
- q_m[0] = d[0].
- q_m[i] = q_m[i-1] XNOR d[i] (XNOR mode) or XOR d[i] (XOR mode), i = 1..7.
- q_m[8] = 0 in XNOR mode, 1 in XOR mode.

Running disparity:
- cnt is 5-bit two's complement. All disparity arithmetic is done signed, 5 bits wide.

S3 output when de=1 (three cases, checked in order):
- Case A, cnt==0 or n1q==n0q:
  - data_out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
  - If q_m[8]=1: cnt += n1q-n0q. If q_m[8]=0: cnt += n0q-n1q.
- Case B, (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
  - data_out = {1, q_m[8], ~q_m[7:0]}.
  - cnt += 2*q_m[8] + (n0q-n1q).
- Case C, all other cases:
  - data_out = {0, q_m[8], q_m[7:0]}.
  - cnt += -2*(~q_m[8]) + (n1q-n0q).

S3 output when de=0:
- cnt <= 0.
- data_out is selected by {c1,c0}:
  - 00 -> 10'b1101010100
  - 01 -> 10'b0010101011
  - 10 -> 10'b0101010100
  - 11 -> 10'b1010101011

Boundary conditions:
- de toggling on consecutive cycles is legal. Each cycle is encoded independently, and cnt is cleared on every de=0 cycle.
- |cnt| must never exceed 10 for legal input.
- The first data character after blanking always uses Case A (cnt=0).

Test Plan:
1. Reset: hold sys_rst_n=0 for 5 cycles with random inputs -> data_out=10'h000 throughout; 3 cycles after release, the first encoded value appears.
2. Control codes: de=0 while {c1,c0} cycles 00,01,10,11 -> data_out = 354h, 0ABh, 154h, 2ABh, each 3 cycles after its input.
3. Data 8'h00, then 8'h00, after blanking -> data_out=10'h100 (cnt becomes -8), then 10'h3FF (cnt becomes +2).
4. Data 8'hFF after blanking -> data_out=10'h200 (XNOR mode, q_m=0FFh, cnt becomes -8). A blanking cycle, then 8'hFF again -> 10'h200 again (cnt was cleared).
5. Latency and DC balance:
   - Pulse de for one cycle at edge N -> data character on data_out at edge N+3, control codes on either side.
   - Long random de=1 burst checked against a reference model: bit-exact match; |cnt| ≤ 10; cumulative ones minus zeros in the output stays bounded.
6. Reset mid-burst: assert sys_rst_n=0 while cnt≠0 -> next edge data_out=0 and cnt=0. After release, the first data character is encoded as Case A.

Source files
------------

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - TMDS 8b/10b encoder for one colour channel, 3-stage pipeline
// q_m is built in stage 2; stage 3 applies DC balancing against the running disparity cnt.
module tmds_encoder (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] data_in,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output logic [9:0] data_out
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  // Stage 1
  logic [7:0] d1;
  logic       de1, c0_1, c1_1;
  logic [3:0] n1d;

  // Stage 2
  logic [8:0] q_m;
  logic       de2, c0_2, c1_2;
  logic [3:0] n1q, n0q;

  logic signed [4:0] cnt;

  logic [8:0] q_m_next;
  always_comb begin
    logic       xnor_mode;
    logic [8:0] q;
    xnor_mode = (n1d > 4'd4) || ((n1d == 4'd4) && !d1[0]);
    q         = '0;
    q[0]      = d1[0];
    for (int i = 1; i < 8; i++)
      q[i] = xnor_mode ? ~(q[i-1] ^ d1[i]) : (q[i-1] ^ d1[i]);
    q[8]     = ~xnor_mode;
    q_m_next = q;
  end

  logic signed [4:0] n1s, n0s, diff, two_q8, two_nq8;
  logic signed [4:0] cnt_next;
  logic [9:0]        word_next;

  assign n1s     = $signed({1'b0, n1q});
  assign n0s     = $signed({1'b0, n0q});
  assign diff    = n1s - n0s;
  assign two_q8  = $signed({3'b000, q_m[8], 1'b0});
  assign two_nq8 = $signed({3'b000, ~q_m[8], 1'b0});

  always_comb begin
    word_next = '0;
    cnt_next  = cnt;
    if (!de2) begin
      cnt_next = '0;
      case ({c1_2, c0_2})
        2'b00:   word_next = 10'b1101010100;
        2'b01:   word_next = 10'b0010101011;
        2'b10:   word_next = 10'b0101010100;
        default: word_next = 10'b1010101011;
      endcase
    end else if ((cnt == 5'sd0) || (n1q == n0q)) begin
      word_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_next  = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (n1q > n0q)) || ((cnt < 5'sd0) && (n0q > n1q))) begin
      word_next = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next  = cnt + two_q8 - diff;
    end else begin
      word_next = {1'b0, q_m[8], q_m[7:0]};
      cnt_next  = cnt - two_nq8 + diff;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      d1       <= '0;
      de1      <= 1'b0;
      c0_1     <= 1'b0;
      c1_1     <= 1'b0;
      n1d      <= '0;
      q_m      <= '0;
      de2      <= 1'b0;
      c0_2     <= 1'b0;
      c1_2     <= 1'b0;
      n1q      <= '0;
      n0q      <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      d1       <= data_in;
      de1      <= de;
      c0_1     <= c0;
      c1_1     <= c1;
      n1d      <= popcount8(data_in);
      q_m      <= q_m_next;
      de2      <= de1;
      c0_2     <= c0_1;
      c1_2     <= c1_1;
      n1q      <= popcount8(q_m_next[7:0]);
      n0q      <= popcount8(~q_m_next[7:0]);
      cnt      <= cnt_next;
      data_out <= word_next;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - directed and model-checked bench for tmds_encoder
// Each tick drives one input set; data_out is compared two ticks later (three register stages).
module tb_tmds_encoder;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] data_in;
  logic       c0, c1, de;
  logic [9:0] data_out;

  int errors = 0;
  int checks = 0;
  int bal = 0;
  int max_abs_bal = 0;
  int rd, rd_n;
  logic [7:0] rnd;
  logic [9:0] e;

  logic [9:0] q_exp[$];
  bit         q_de[$];
  string      q_tag[$];

  tmds_encoder dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .data_in  (data_in),
    .c0       (c0),
    .c1       (c1),
    .de       (de),
    .data_out (data_out)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  function automatic logic [9:0] ref_enc(input logic [7:0] d, input int rd_in, output int rd_out);
    int ones, a, b, q8;
    bit inv;
    logic [8:0] q;
    logic [9:0] w;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    inv  = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = inv ? (q[i-1] == d[i]) : (q[i-1] != d[i]);
    q[8] = !inv;
    q8   = q[8] ? 1 : 0;
    a    = 0;
    for (int i = 0; i < 8; i++) a += int'(q[i]);
    b = 8 - a;
    if (rd_in == 0 || a == b) begin
      if (q[8]) begin w = {2'b01, q[7:0]};  rd_out = rd_in + a - b; end
      else      begin w = {2'b10, ~q[7:0]}; rd_out = rd_in + b - a; end
    end else if ((rd_in > 0 && a > b) || (rd_in < 0 && b > a)) begin
      w = {1'b1, q[8], ~q[7:0]};
      rd_out = rd_in + 2 * q8 + b - a;
    end else begin
      w = {1'b0, q[8], q[7:0]};
      rd_out = rd_in - 2 * (1 - q8) + a - b;
    end
    return w;
  endfunction

  task automatic check(input logic [9:0] obs, input logic [9:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: data_out=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic rn, input logic de_i, input logic c1_i, input logic c0_i,
                      input logic [7:0] d, input logic [9:0] exp, input string tag);
    logic [9:0] pe;
    bit         pd;
    string      pt;
    @(negedge sys_clk);
    sys_rst_n = rn;
    de        = de_i;
    c1        = c1_i;
    c0        = c0_i;
    data_in   = d;
    if (rn) begin
      q_exp.push_back(exp);
      q_de.push_back(de_i);
      q_tag.push_back(tag);
    end
    @(posedge sys_clk);
    #1;
    if (!rn) begin
      check(data_out, 10'h000, tag);
      // cleared pipeline carries de=0, {c1,c0}=00 for two edges after release
      q_exp = '{10'h354, 10'h354};
      q_de  = '{1'b0, 1'b0};
      q_tag = '{"post_reset_pipe", "post_reset_pipe"};
      bal   = 0;
    end else if (q_exp.size() == 3) begin
      pe = q_exp.pop_front();
      pd = q_de.pop_front();
      pt = q_tag.pop_front();
      check(data_out, pe, pt);
      if (pd) begin
        bal += 2 * $countones(data_out) - 10;
        if (bal > max_abs_bal) max_abs_bal = bal;
        if (-bal > max_abs_bal) max_abs_bal = -bal;
      end else begin
        bal = 0;
      end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    de = 1'b0; c0 = 1'b0; c1 = 1'b0; data_in = '0;

    for (int i = 0; i < 5; i++)
      tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 10'h000, "reset");

    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'h354, "ctrl_00");
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 10'h0AB, "ctrl_01");
    tick(1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 10'h154, "ctrl_10");
    tick(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 10'h2AB, "ctrl_11");

    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'h100, "d00_first");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'h3FF, "d00_second");
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'h354, "blank_a");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 10'h200, "dff_first");
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'h354, "blank_b");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 10'h200, "dff_after_blank");
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'h354, "blank_c");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 10'h133, "d55_xor_tie");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 10'h1F0, "d10_balanced");

    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 10'h0AB, "pulse_pre");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'h100, "pulse_data");
    tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 10'h154, "pulse_post");

    rd = 0;
    for (int i = 0; i < 200; i++) begin
      rnd = 8'($urandom_range(0, 255));
      e   = ref_enc(rnd, rd, rd_n);
      rd  = rd_n;
      tick(1'b1, 1'b1, 1'b0, 1'b0, rnd, e, "burst");
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'h354, "blank_d");

    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'h100, "mid_d1");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'h3FF, "mid_d2");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'h100, "mid_d3");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'h3FF, "mid_d4");
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 10'h000, "mid_reset");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'h100, "after_reset_caseA");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'h3FF, "after_reset_second");
    tick(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 10'h2AB, "tail_a");
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'h354, "tail_b");
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'h354, "tail_c");

    checks++;
    assert (max_abs_bal <= 10) else begin
      errors++;
      $error("FAIL dc_balance: max |ones-zeros|=%0d expected <= 10", max_abs_bal);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
